// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES serial host: FSM state encoding,
// block width and the frame-length helper.
package aes_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_OUT,
      WAIT_DONE,
      SHIFT_IN,
      RESULT
   } state_t;

   localparam int BLOCK_BITS = 128;

   function automatic int frame_bits(input int k);
      return k + BLOCK_BITS;
   endfunction

endpackage

// File: rtl/aes_spi_sck_gen.sv
// Serial clock generator: each bit slot is 2*SCK_DIV clk cycles, low half first.
// The counter is held at zero whenever en is low, so every phase starts at slot 0.
module aes_spi_sck_gen
   import aes_spi_pkg::*;
#(
   parameter int SCK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic sck,
   output logic fall_tick,
   output logic rise_end
);

   localparam int SLOT = 2 * SCK_DIV;
   localparam int CW   = $clog2(SLOT);
   localparam logic [CW-1:0] LAST = CW'(SLOT - 1);
   localparam logic [CW-1:0] HALF = CW'(SCK_DIV);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          sck_q;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= (cnt_d >= HALF);
      end
   end

   // The last cycle of the slot is also the last cycle of the high phase.
   assign sck       = sck_q;
   assign fall_tick = en && (cnt_q == LAST);
   assign rise_end  = en && (cnt_q == LAST);

endmodule

// File: rtl/aes_spi_host.sv
// SPI master for the invaes slave port: shifts {cyphertext, key} out, waits for
// done, reads 128 plaintext bits back. Optional done-wait timeout: AES_HOST_TIMEOUT_EN.
module aes_spi_host
   import aes_spi_pkg::*;
#(
   parameter int K       = 256,
   parameter int SCK_DIV = 2,
   parameter int TMO_MAX = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [K-1:0]          key,
   input  logic [BLOCK_BITS-1:0] cyphertext,
   output logic                  busy,
   output logic [BLOCK_BITS-1:0] result,
   output logic                  result_valid,
   output logic                  err,
   output logic                  sck,
   output logic                  sdi,
   output logic                  load,
   input  logic                  sdo,
   input  logic                  done
);

   localparam int N  = frame_bits(K);
   localparam int BW = $clog2(N + 1);
   localparam logic [BW-1:0] LAST_OUT = BW'(N - 1);
   localparam logic [BW-1:0] LAST_IN  = BW'(BLOCK_BITS - 1);

   if (SCK_DIV < 1 || TMO_MAX < 1 || (K != 128 && K != 192 && K != 256)) begin : g_param_check
      $error("aes_spi_host: illegal parameter value");
   end

   state_t                state_q;
   logic [N-1:0]          sr_q;
   logic [BLOCK_BITS-1:0] rx_q;
   logic [BLOCK_BITS-1:0] rx_d;
   logic [BLOCK_BITS-1:0] result_q;
   logic [BW-1:0]         bit_q;
   logic                  busy_q;
   logic                  result_valid_q;
   logic                  sdi_q;
   logic                  load_q;
   logic                  sck_en;
   logic                  fall_tick;
   logic                  rise_end;

   assign sck_en = (state_q == SHIFT_OUT) || (state_q == SHIFT_IN);
   assign rx_d   = {rx_q[BLOCK_BITS-2:0], sdo};

   aes_spi_sck_gen #(
      .SCK_DIV (SCK_DIV)
   ) u_sck_gen (
      .clk       (clk),
      .reset     (reset),
      .en        (sck_en),
      .sck       (sck),
      .fall_tick (fall_tick),
      .rise_end  (rise_end)
   );

`ifdef AES_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TMO_MAX + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_MAX - 1);
   logic [TW-1:0] tmo_q;
   logic          err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         sr_q           <= '0;
         rx_q           <= '0;
         result_q       <= '0;
         bit_q          <= '0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         sdi_q          <= 1'b0;
         load_q         <= 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
         tmo_q          <= '0;
         err_q          <= 1'b0;
`endif
      end else begin
         result_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  sr_q    <= {cyphertext, key};
                  sdi_q   <= cyphertext[BLOCK_BITS-1];
                  load_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  bit_q   <= '0;
                  state_q <= SETUP;
`ifdef AES_HOST_TIMEOUT_EN
                  tmo_q   <= '0;
                  err_q   <= 1'b0;
`endif
               end
            end
            SETUP: state_q <= SHIFT_OUT;
            SHIFT_OUT: begin
               // sdi only moves on the edge where sck falls, never mid-slot.
               if (fall_tick) begin
                  if (bit_q == LAST_OUT) begin
                     load_q  <= 1'b0;
                     sdi_q   <= 1'b0;
                     bit_q   <= '0;
                     state_q <= WAIT_DONE;
                  end else begin
                     bit_q <= bit_q + BW'(1);
                     sr_q  <= sr_q << 1;
                     sdi_q <= sr_q[N-2];
                  end
               end
            end
            WAIT_DONE: begin
               if (done) begin
                  state_q <= SHIFT_IN;
               end
`ifdef AES_HOST_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
`endif
            end
            SHIFT_IN: begin
               if (rise_end) begin
                  rx_q <= rx_d;
                  if (bit_q == LAST_IN) begin
                     result_q       <= rx_d;
                     result_valid_q <= 1'b1;
                     state_q        <= RESULT;
                  end else begin
                     bit_q <= bit_q + BW'(1);
                  end
               end
            end
            RESULT: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign sdi          = sdi_q;
   assign load         = load_q;

endmodule

// File: tb/tb_aes_spi_host.sv
// Bench for aes_spi_host: three host instances (K/SCK_DIV variants), each paired
// with a behavioural invaes slave that answers its known-answer vector.
module tb_aes_spi_host;

   localparam int NI = 3;
   localparam int KV [NI] = '{128, 256, 192};
   localparam int DV [NI] = '{2, 2, 1};
   localparam logic [127:0] CTV [NI] = '{
      128'h3925841D02DC09FBDC118597196A0B32,
      128'h8ea2b7ca516745bfeafc49904b496089,
      128'hdda97ca4864cdfe06eaf70a0ec0d7191};
   localparam logic [255:0] KEYV [NI] = '{
      256'h2B7E151628AED2A6ABF7158809CF4F3C,
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
      256'h000102030405060708090a0b0c0d0e0f1011121314151617};
   localparam logic [127:0] PTV [NI] = '{
      128'h3243F6A8885A308D313198A2E0370734,
      128'h00112233445566778899aabbccddeeff,
      128'h00112233445566778899aabbccddeeff};
   // Start-to-result_valid latency with the slave's done arriving on the 3rd WAIT_DONE cycle.
   localparam int LATV [NI] = '{1541, 2053, 901};

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_a [NI];
   logic [255:0] key_a [NI];
   logic [127:0] ct_a [NI];
   logic         busy_a [NI];
   logic [127:0] res_a [NI];
   logic         rv_a [NI];
   logic         err_a [NI];
   logic         sck_a [NI];
   logic         sdi_a [NI];
   logic         load_a [NI];
   logic         sdo_a [NI];
   logic         done_a [NI];
   bit           done_en [NI];
   bit           done_force [NI];
   bit           done_pulse [NI];
   int           rises_a [NI];
   int           viol_a [NI];
   int           tests = 0;
   int           fails = 0;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_inst
         localparam int KK = KV[gi];
         localparam int NN = KK + 128;
         localparam logic [255:0] KEY_G = KEYV[gi];
         localparam logic [127:0] CT_G = CTV[gi];
         localparam logic [127:0] PT_G = PTV[gi];

         logic [NN-1:0] frame_q;
         logic [127:0]  out_q;
         logic          done_q, armed_q, sck_p, load_p, sck_m, load_m, sdi_m;

         aes_spi_host #(.K(KK), .SCK_DIV(DV[gi]), .TMO_MAX(16)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start_a[gi]),
            .key          (key_a[gi][KK-1:0]),
            .cyphertext   (ct_a[gi]),
            .busy         (busy_a[gi]),
            .result       (res_a[gi]),
            .result_valid (rv_a[gi]),
            .err          (err_a[gi]),
            .sck          (sck_a[gi]),
            .sdi          (sdi_a[gi]),
            .load         (load_a[gi]),
            .sdo          (sdo_a[gi]),
            .done         (done_a[gi])
         );

         assign sdo_a[gi]  = out_q[127];
         assign done_a[gi] = done_q | done_force[gi];

         // Slave: capture frame on sck rise, answer after load falls, shift result on sck fall.
         always @(posedge clk) begin
            if (reset) begin
               frame_q <= '0; out_q <= '0; done_q <= 1'b0; armed_q <= 1'b0;
               sck_p <= 1'b0; load_p <= 1'b0;
            end else begin
               sck_p  <= sck_a[gi];
               load_p <= load_a[gi];
               if (sck_a[gi] && !sck_p && load_a[gi])
                  frame_q <= {frame_q[NN-2:0], sdi_a[gi]};
               if (!load_a[gi] && load_p) begin
                  if (frame_q[NN-1 -: 128] == CT_G && frame_q[KK-1:0] == KEY_G[KK-1:0])
                     out_q <= PT_G;
                  else
                     out_q <= ~frame_q[NN-1 -: 128];
                  armed_q <= done_en[gi];
               end else if (!sck_a[gi] && sck_p) begin
                  out_q <= {out_q[126:0], 1'b0};
               end
               if (load_a[gi] && !load_p) done_q <= 1'b0;
               else if (armed_q) begin done_q <= 1'b1; armed_q <= 1'b0; end
               else if (done_q && done_pulse[gi]) done_q <= 1'b0;
            end
         end

         always @(negedge clk) begin
            sck_m  <= sck_a[gi];
            load_m <= load_a[gi];
            sdi_m  <= sdi_a[gi];
            if (reset) begin
               rises_a[gi] <= 0;
               viol_a[gi]  <= 0;
            end else begin
               if (load_a[gi] && !load_m) rises_a[gi] <= 0;
               else if (load_a[gi] && sck_a[gi] && !sck_m) rises_a[gi] <= rises_a[gi] + 1;
               if (sck_a[gi] && (sdi_a[gi] !== sdi_m)) viol_a[gi] <= viol_a[gi] + 1;
            end
         end
      end
   endgenerate

   task automatic do_txn(input int idx, input logic [127:0] ct, input logic [255:0] k,
                         output int lat, output int pulses, output logic [127:0] res,
                         output bit hung);
      int n;
      @(negedge clk);
      ct_a[idx] = ct; key_a[idx] = k; start_a[idx] = 1'b1;
      @(negedge clk);
      start_a[idx] = 1'b0;
      n = 1; lat = -1; pulses = 0; hung = 1'b1;
      while (n < 4000) begin
         if (rv_a[idx]) begin pulses++; if (lat < 0) lat = n; end
         if (!busy_a[idx]) begin hung = 1'b0; break; end
         @(negedge clk);
         n++;
      end
      repeat (3) begin
         @(negedge clk);
         if (rv_a[idx]) pulses++;
      end
      res = res_a[idx];
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         tests++;
         if ({sck_a[i], sdi_a[i], load_a[i], busy_a[i], rv_a[i], err_a[i]} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl[%0d]: got sck,sdi,load,busy,rv,err=%b%b%b%b%b%b want 000000",
                     i, sck_a[i], sdi_a[i], load_a[i], busy_a[i], rv_a[i], err_a[i]);
         end
         tests++;
         if (res_a[i] !== 128'h0) begin
            fails++;
            $display("FAIL reset_result[%0d]: got %h want 0", i, res_a[i]);
         end
      end
   endtask

   task automatic test_vector(input int idx, input int exp_lat);
      int lat, pulses;
      logic [127:0] res;
      bit hung;
      do_txn(idx, CTV[idx], KEYV[idx], lat, pulses, res, hung);
      tests++;
      if (hung) begin fails++; $display("FAIL vec%0d_hang: busy still high after 4000 cycles", idx); end
      tests++;
      if (res !== PTV[idx]) begin
         fails++; $display("FAIL vec%0d_result: got %h want %h", idx, res, PTV[idx]);
      end
      tests++;
      if (pulses !== 1) begin
         fails++; $display("FAIL vec%0d_pulses: got %0d want 1", idx, pulses);
      end
      tests++;
      if (lat !== exp_lat) begin
         fails++; $display("FAIL vec%0d_latency: got %0d want %0d", idx, lat, exp_lat);
      end
      tests++;
      if (err_a[idx] !== 1'b0 || busy_a[idx] !== 1'b0) begin
         fails++; $display("FAIL vec%0d_status: got err=%b busy=%b want 0 0", idx, err_a[idx], busy_a[idx]);
      end
      $display("[TB] vec%0d K=%0d div=%0d latency=%0d result=%h", idx, KV[idx], DV[idx], lat, res);
   endtask

   task automatic test_frame_shape;
      test_vector(2, LATV[2]);
      tests++;
      if (rises_a[2] !== 320) begin
         fails++; $display("FAIL frame_rises: got %0d sck rises with load want 320", rises_a[2]);
      end
      tests++;
      if (viol_a[2] !== 0) begin
         fails++; $display("FAIL sdi_stable: got %0d sdi changes while sck high want 0", viol_a[2]);
      end
   endtask

   task automatic test_done_on_entry;
      done_force[0] = 1'b1;
      test_vector(0, 1539);
      done_force[0] = 1'b0;
   endtask

   task automatic test_done_drop;
      done_pulse[2] = 1'b1;
      test_vector(2, LATV[2]);
      done_pulse[2] = 1'b0;
   endtask

   task automatic test_reset_mid;
      int n;
      @(negedge clk);
      ct_a[0] = CTV[0]; key_a[0] = KEYV[0]; start_a[0] = 1'b1;
      @(negedge clk);
      start_a[0] = 1'b0;
      n = 0;
      while (rises_a[0] != 41 && n < 2000) begin @(negedge clk); n++; end
      tests++;
      if (rises_a[0] != 41) begin
         fails++; $display("FAIL rst_mid_reach: never reached bit 40, rises=%0d", rises_a[0]);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++;
      if ({sck_a[0], sdi_a[0], load_a[0], busy_a[0], rv_a[0], err_a[0]} !== 6'b0 || res_a[0] !== 128'h0) begin
         fails++;
         $display("FAIL rst_mid_outputs: got sck,sdi,load,busy,rv,err=%b%b%b%b%b%b result=%h want all 0",
                  sck_a[0], sdi_a[0], load_a[0], busy_a[0], rv_a[0], err_a[0], res_a[0]);
      end
      test_vector(0, LATV[0]);
   endtask

   task automatic test_back_to_back;
      int n, gap;
      @(negedge clk);
      ct_a[0] = CTV[0]; key_a[0] = KEYV[0]; start_a[0] = 1'b1;
      n = 0;
      while (!rv_a[0] && n < 3000) begin @(negedge clk); n++; end
      tests++;
      if (!rv_a[0]) begin
         fails++; $display("FAIL b2b_first: no result_valid within %0d cycles", n);
         start_a[0] = 1'b0;
         return;
      end
      @(negedge clk);
      tests++;
      if (busy_a[0] !== 1'b0 || load_a[0] !== 1'b0) begin
         fails++; $display("FAIL b2b_idle: got busy=%b load=%b want 0 0", busy_a[0], load_a[0]);
      end
      @(negedge clk);
      tests++;
      if (busy_a[0] !== 1'b1 || load_a[0] !== 1'b1) begin
         fails++; $display("FAIL b2b_restart: got busy=%b load=%b want 1 1", busy_a[0], load_a[0]);
      end
      gap = 2;
      while (!rv_a[0] && gap < 3000) begin @(negedge clk); gap++; end
      start_a[0] = 1'b0;
      tests++;
      if (gap !== 1542) begin
         fails++; $display("FAIL b2b_gap: got %0d cycles between pulses want 1542", gap);
      end
      tests++;
      if (res_a[0] !== PTV[0]) begin
         fails++; $display("FAIL b2b_result: got %h want %h", res_a[0], PTV[0]);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (busy_a[0] !== 1'b0) begin
         fails++; $display("FAIL b2b_stop: got busy=%b want 0 after start dropped", busy_a[0]);
      end
      $display("[TB] back_to_back gap=%0d result=%h", gap, res_a[0]);
   endtask

`ifdef AES_HOST_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      bit rv_seen;
      logic [127:0] prior;
      done_en[0] = 1'b0;
      prior = res_a[0];
      @(negedge clk);
      ct_a[0] = CTV[0]; key_a[0] = KEYV[0]; start_a[0] = 1'b1;
      @(negedge clk);
      start_a[0] = 1'b0;
      n = 0;
      while (load_a[0] && n < 2000) begin @(negedge clk); n++; end
      n = 0; rv_seen = 1'b0;
      while (!err_a[0] && n < 100) begin
         @(negedge clk);
         n++;
         if (rv_a[0]) rv_seen = 1'b1;
      end
      tests++;
      if (n !== 16) begin fails++; $display("FAIL tmo_delay: got err after %0d cycles want 16", n); end
      tests++;
      if (busy_a[0] !== 1'b0 || rv_seen) begin
         fails++; $display("FAIL tmo_status: got busy=%b rv_seen=%b want 0 0", busy_a[0], rv_seen);
      end
      tests++;
      if (res_a[0] !== prior) begin
         fails++; $display("FAIL tmo_result: got %h want %h", res_a[0], prior);
      end
      $display("[TB] timeout err after %0d cycles", n);
      done_en[0] = 1'b1;
   endtask
`endif

   initial begin
      for (int i = 0; i < NI; i++) begin
         start_a[i] = 1'b0; key_a[i] = '0; ct_a[i] = '0;
         done_en[i] = 1'b1; done_force[i] = 1'b0; done_pulse[i] = 1'b0;
      end
      test_reset();
      test_vector(0, LATV[0]);
      test_vector(1, LATV[1]);
      test_frame_shape();
      test_done_on_entry();
      test_done_drop();
      test_back_to_back();
`ifdef AES_HOST_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
